stopwatch_counter: RTL and testbench

Minutes:seconds BCD counter for the stopwatch datapath. Sits directly downstream of the adjust-pulse generator: consumes its `sig_minute_adj` and `sig_second_adj` pulse trains and the `adj_state` select, advances time on a 1 Hz strobe, and supports pause/resume. Its four BCD digits feed the 7-segment display driver.

---
 rtl/stopwatch_counter.sv | 225 ++++++++++++++++++++++
 tb/tb_stopwatch_counter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Minutes:seconds BCD stopwatch counter. Advances on a 1 Hz strobe in RUN,
//   holds in PAUSED, and in ADJUST steps minutes or seconds on rising edges of
//   the adjust pulse trains. Feeds four BCD digits to the display driver.
//
// Optional feature macro: STOPWATCH_BLINK_EN
//   Defined   : a blink toggle flop drives blank_min / blank_sec in ADJUST.
//   Undefined : blank_min / blank_sec are tied low and tick_blink is unused.
//
// Ports
//   clk_sys        in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   tick_1hz       in   one-cycle strobe per second
//   tick_blink     in   one-cycle 2 Hz strobe (blink build only)
//   pause_btn      in   one-cycle pulse toggling run/pause
//   adj_state[1:0] in   00 normal, 01 minute adjust, 10 second adjust, 11 normal
//   sig_minute_adj in   minute-adjust pulse train (rising edge = one event)
//   sig_second_adj in   second-adjust pulse train (rising edge = one event)
//   min_tens, min_ones, sec_tens, sec_ones  out  BCD digits
//   paused         out  high in PAUSED
//   adjusting      out  high in ADJUST
//   wrap           out  one-cycle pulse on MAX_MIN:59 -> 00:00
//   blank_min      out  blank the minute field
//   blank_sec      out  blank the second field

module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       tick_blink,
  input  logic       pause_btn,
  input  logic [1:0] adj_state,
  input  logic       sig_minute_adj,
  input  logic       sig_second_adj,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       adjusting,
  output logic       wrap,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSED = 2'd1,
    S_ADJUST = 2'd2
  } state_t;

  state_t     r_state, w_nextState;
  logic       r_resumeRun;
  logic       r_paused, r_adjusting, r_wrap;
  logic       w_nextPaused, w_nextAdjusting;
  logic [3:0] r_minTens, r_minOnes, r_secTens, r_secOnes;
  logic [3:0] w_minTensN, w_minOnesN, w_secTensN, w_secOnesN;
  logic       w_wrapN;
  logic       r_minAdjCur, r_minAdjPrev, r_secAdjCur, r_secAdjPrev;
  logic       w_minEvent, w_secEvent;
  logic       w_adjReq, w_tickRun, w_secAtMax, w_minAtMax, w_minInc, w_secInc;

  // 01 and 10 request adjust; 00 and 11 both mean normal operation.
  assign w_adjReq   = (adj_state == 2'b01) || (adj_state == 2'b10);
  assign w_minEvent = r_minAdjCur & ~r_minAdjPrev;
  assign w_secEvent = r_secAdjCur & ~r_secAdjPrev;

  // State register, plus the registered status outputs and the resume flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RUN;
      r_resumeRun <= 1'b1;
      r_paused    <= 1'b0;
      r_adjusting <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_paused    <= w_nextPaused;
      r_adjusting <= w_nextAdjusting;
      if ((r_state != S_ADJUST) && (w_nextState == S_ADJUST))
        r_resumeRun <= (r_state == S_RUN);
    end
  end

  // Next-state logic. Adjust requests take precedence over pause_btn.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_adjReq)       w_nextState = S_ADJUST;
        else if (pause_btn) w_nextState = S_PAUSED;
      end
      S_PAUSED: begin
        if (w_adjReq)       w_nextState = S_ADJUST;
        else if (pause_btn) w_nextState = S_RUN;
      end
      S_ADJUST: begin
        if (!w_adjReq)      w_nextState = r_resumeRun ? S_RUN : S_PAUSED;
      end
      default:              w_nextState = S_RUN;
    endcase
  end

  // Status outputs are decoded from the next state so the registered copies
  // change together with the state register.
  always_comb begin
    w_nextPaused    = (w_nextState == S_PAUSED);
    w_nextAdjusting = (w_nextState == S_ADJUST);
  end

  // Edge detection: each adjust input is registered, and a rising edge is
  // seen one cycle later as current = 1, previous = 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_minAdjCur  <= 1'b0;
      r_minAdjPrev <= 1'b0;
      r_secAdjCur  <= 1'b0;
      r_secAdjPrev <= 1'b0;
    end else begin
      r_minAdjCur  <= sig_minute_adj;
      r_minAdjPrev <= r_minAdjCur;
      r_secAdjCur  <= sig_second_adj;
      r_secAdjPrev <= r_secAdjCur;
    end
  end

  assign w_tickRun  = (r_state == S_RUN) && tick_1hz;
  assign w_secAtMax = (r_secTens == 4'd5) && (r_secOnes == 4'd9);
  assign w_minAtMax = (r_minTens == MAX_TENS) && (r_minOnes == MAX_ONES);
  // Adjust events only count once the FSM is already in ADJUST, and only
  // when their type matches the selected field; seconds never carry here.
  assign w_secInc   = w_tickRun ||
                      ((r_state == S_ADJUST) && (adj_state == 2'b10) && w_secEvent);
  assign w_minInc   = (w_tickRun && w_secAtMax) ||
                      ((r_state == S_ADJUST) && (adj_state == 2'b01) && w_minEvent);

  // BCD increment of both fields; minutes roll over after MAX_MIN.
  always_comb begin
    w_secOnesN = r_secOnes;
    w_secTensN = r_secTens;
    w_minOnesN = r_minOnes;
    w_minTensN = r_minTens;
    w_wrapN    = w_tickRun && w_secAtMax && w_minAtMax;
    if (w_secInc) begin
      if (r_secOnes == 4'd9) begin
        w_secOnesN = 4'd0;
        w_secTensN = (r_secTens == 4'd5) ? 4'd0 : r_secTens + 4'd1;
      end else begin
        w_secOnesN = r_secOnes + 4'd1;
      end
    end
    if (w_minInc) begin
      if (w_minAtMax) begin
        w_minOnesN = 4'd0;
        w_minTensN = 4'd0;
      end else if (r_minOnes == 4'd9) begin
        w_minOnesN = 4'd0;
        w_minTensN = r_minTens + 4'd1;
      end else begin
        w_minOnesN = r_minOnes + 4'd1;
      end
    end
  end

  // Digit and wrap registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_secOnes <= 4'd0;
      r_secTens <= 4'd0;
      r_minOnes <= 4'd0;
      r_minTens <= 4'd0;
      r_wrap    <= 1'b0;
    end else begin
      r_secOnes <= w_secOnesN;
      r_secTens <= w_secTensN;
      r_minOnes <= w_minOnesN;
      r_minTens <= w_minTensN;
      r_wrap    <= w_wrapN;
    end
  end

  assign min_tens  = r_minTens;
  assign min_ones  = r_minOnes;
  assign sec_tens  = r_secTens;
  assign sec_ones  = r_secOnes;
  assign paused    = r_paused;
  assign adjusting = r_adjusting;
  assign wrap      = r_wrap;

`ifdef STOPWATCH_BLINK_EN
  logic r_blink, w_blinkNext, r_blankMin, r_blankSec;

  // Blink toggle runs only while in ADJUST and is held clear elsewhere.
  always_comb begin
    w_blinkNext = 1'b0;
    if (r_state == S_ADJUST)
      w_blinkNext = tick_blink ? ~r_blink : r_blink;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_blink    <= 1'b0;
      r_blankMin <= 1'b0;
      r_blankSec <= 1'b0;
    end else begin
      r_blink    <= w_blinkNext;
      r_blankMin <= w_blinkNext & (adj_state == 2'b01);
      r_blankSec <= w_blinkNext & (adj_state == 2'b10);
    end
  end

  assign blank_min = r_blankMin;
  assign blank_sec = r_blankSec;
`else
  logic w_unusedBlink;
  assign w_unusedBlink = tick_blink;
  assign blank_min     = 1'b0;
  assign blank_sec     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Self-checking bench for stopwatch_counter. A time-in-seconds reference
//   model is stepped alongside the design; directed sequences walk through the
//   main use cases and a randomized phase mixes all inputs.

module tb_stopwatch_counter;

  localparam int MAX_MIN = 59;
  localparam int M_RUN = 0, M_PAUSED = 1, M_ADJUST = 2;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       tick_1hz, tick_blink, pause_btn;
  logic [1:0] adj_state;
  logic       sig_minute_adj, sig_second_adj;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused, adjusting, wrap, blank_min, blank_sec;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain minute/second integers and a mode number.
  int mMin, mSec, mState;
  bit mResume, mWrap, mBlink, mBlankMin, mBlankSec;
  bit mMinLast, mMinBefore, mSecLast, mSecBefore;

  stopwatch_counter #(.MAX_MIN(MAX_MIN)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick_1hz(tick_1hz),
    .tick_blink(tick_blink), .pause_btn(pause_btn), .adj_state(adj_state),
    .sig_minute_adj(sig_minute_adj), .sig_second_adj(sig_second_adj),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .paused(paused), .adjusting(adjusting), .wrap(wrap),
    .blank_min(blank_min), .blank_sec(blank_sec)
  );

  always #5 clk_sys = ~clk_sys;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMin = 0; mSec = 0; mState = M_RUN; mResume = 1'b1; mWrap = 1'b0;
    mBlink = 1'b0; mBlankMin = 1'b0; mBlankSec = 1'b0;
    mMinLast = 1'b0; mMinBefore = 1'b0; mSecLast = 1'b0; mSecBefore = 1'b0;
  endtask

  // One clock edge of the reference model, from the inputs present at it.
  task automatic modelStep(input bit tick, input bit pause, input bit [1:0] adj,
                           input bit minIn, input bit secIn, input bit blinkIn);
    bit evMin, evSec, adjReq;
    int total;
    evMin = mMinLast && !mMinBefore;
    evSec = mSecLast && !mSecBefore;
    mMinBefore = mMinLast; mMinLast = minIn;
    mSecBefore = mSecLast; mSecLast = secIn;
    adjReq = (adj == 2'd1) || (adj == 2'd2);
    mWrap = 1'b0;
    if (mState == M_RUN && tick) begin
      total = mMin * 60 + mSec + 1;
      if (total == (MAX_MIN + 1) * 60) begin
        total = 0;
        mWrap = 1'b1;
      end
      mMin = total / 60;
      mSec = total % 60;
    end
    if (mState == M_ADJUST) begin
      if (evMin && adj == 2'd1) mMin = (mMin + 1) % (MAX_MIN + 1);
      if (evSec && adj == 2'd2) mSec = (mSec + 1) % 60;
    end
`ifdef STOPWATCH_BLINK_EN
    if (mState == M_ADJUST) begin
      if (blinkIn) mBlink = !mBlink;
    end else begin
      mBlink = 1'b0;
    end
    mBlankMin = mBlink && (adj == 2'd1);
    mBlankSec = mBlink && (adj == 2'd2);
`else
    if (blinkIn) mBlink = 1'b0;
    mBlankMin = 1'b0;
    mBlankSec = 1'b0;
`endif
    case (mState)
      M_RUN: begin
        if (adjReq) begin mResume = 1'b1; mState = M_ADJUST; end
        else if (pause) mState = M_PAUSED;
      end
      M_PAUSED: begin
        if (adjReq) begin mResume = 1'b0; mState = M_ADJUST; end
        else if (pause) mState = M_RUN;
      end
      default: begin
        if (!adjReq) mState = mResume ? M_RUN : M_PAUSED;
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("min_tens", min_tens, mMin / 10);
    checkOutput("min_ones", min_ones, mMin % 10);
    checkOutput("sec_tens", sec_tens, mSec / 10);
    checkOutput("sec_ones", sec_ones, mSec % 10);
    checkOutput("paused", paused, (mState == M_PAUSED));
    checkOutput("adjusting", adjusting, (mState == M_ADJUST));
    checkOutput("wrap", wrap, mWrap);
    checkOutput("blank_min", blank_min, mBlankMin);
    checkOutput("blank_sec", blank_sec, mBlankSec);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(input bit tick, input bit pause, input bit [1:0] adj,
                               input bit minIn, input bit secIn, input bit blinkIn);
    tick_1hz = tick; pause_btn = pause; adj_state = adj;
    sig_minute_adj = minIn; sig_second_adj = secIn; tick_blink = blinkIn;
    @(posedge clk_sys);
    modelStep(tick, pause, adj, minIn, secIn, blinkIn);
    #1;
    checkAll();
  endtask

  task automatic idle(input int n, input bit [1:0] adj);
    repeat (n) applyStimulus(1'b0, 1'b0, adj, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic minPulses(input int n, input bit [1:0] adj);
    repeat (n) begin
      applyStimulus(1'b0, 1'b0, adj, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, adj, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic secPulses(input int n, input int width, input bit [1:0] adj);
    repeat (n) begin
      repeat (width) applyStimulus(1'b0, 1'b0, adj, 1'b0, 1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, adj, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic int digits();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  // Walk to a target time in ADJUST; bounded by the model, never by the DUT.
  task automatic adjustTo(input int targetMin, input int targetSec);
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && mMin != targetMin; i++) minPulses(1, 2'd1);
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && mSec != targetSec; i++) secPulses(1, 1, 2'd2);
  endtask

  initial begin
    bit [1:0] rAdj;
    bit rMin, rSec, rTick, rPause, rBlink;

    reset_n = 1'b0; tick_1hz = 1'b0; tick_blink = 1'b0; pause_btn = 1'b0;
    adj_state = 2'd0; sig_minute_adj = 1'b0; sig_second_adj = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_digits", digits(), 0);
    checkAll();
    @(negedge clk_sys);
    reset_n = 1'b1;

    $display("[TB] 75 ticks from reset");
    ticks(75);
    checkOutput("run75_digits", digits(), 16'h0115);

    $display("[TB] preload 59:58 and wrap");
    adjustTo(59, 58);
    idle(2, 2'd0);
    checkOutput("preload_digits", digits(), 16'h5958);
    checkOutput("preload_run", adjusting, 0);
    ticks(1);
    checkOutput("tick_5959", digits(), 16'h5959);
    checkOutput("wrap_before", wrap, 0);
    ticks(1);
    checkOutput("tick_0000", digits(), 16'h0000);
    checkOutput("wrap_pulse", wrap, 1);
    idle(1, 2'd0);
    checkOutput("wrap_after", wrap, 0);

    $display("[TB] pause and resume");
    ticks(10);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    ticks(5);
    checkOutput("paused_hold", digits(), 16'h0010);
    checkOutput("paused_flag", paused, 1);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    checkOutput("resumed_tick", digits(), 16'h0011);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] second adjust from PAUSED");
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    secPulses(3, 4, 2'd2);
    checkOutput("sec_adj_3", digits(), 16'h0014);
    minPulses(3, 2'd2);
    checkOutput("min_discard", digits(), 16'h0014);
    idle(1, 2'd0);
    checkOutput("back_paused", paused, 1);
    checkOutput("back_not_adj", adjusting, 0);

    $display("[TB] minute adjust wraps without wrap pulse");
    adjustTo(59, 30);
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    minPulses(1, 2'd1);
    checkOutput("min_adj_wrap", digits(), 16'h0030);
    checkOutput("min_adj_nowrap", wrap, 0);
    sig_minute_adj = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_digits", digits(), 0);
    checkAll();
    sig_minute_adj = 1'b0; adj_state = 2'd0;
    @(negedge clk_sys);
    reset_n = 1'b1;

    $display("[TB] blink in minute adjust");
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    idle(1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_BLINK_EN
      checkOutput("blink_min", blank_min, (i % 2 == 0) ? 1 : 0);
`else
      checkOutput("blink_min", blank_min, 0);
`endif
      checkOutput("blink_sec", blank_sec, 0);
      idle(1, 2'd1);
    end
    idle(2, 2'd0);

    $display("[TB] randomized phase");
    rAdj = 2'd0; rMin = 1'b0; rSec = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(29) == 0) rAdj = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) rMin = !rMin;
      if ($urandom_range(2) == 0) rSec = !rSec;
      rTick  = ($urandom_range(3) == 0);
      rBlink = ($urandom_range(3) == 0);
      rPause = (rAdj == 2'd0 || rAdj == 2'd3) && ($urandom_range(9) == 0);
      applyStimulus(rTick, rPause, rAdj, rMin, rSec, rBlink);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
